// File: rtl/vec_gather_i8.sv
// vec_gather_i8 -- stream-to-vector gatherer feeding the adder-tree vector sum.
//
// Collects `lanes` elements per input beat into a `length`-element fill
// buffer. A vector completes on i_last or on its last natural beat. Short
// vectors are zero-padded. Completed vectors move into an output register.
// The fill buffer and the output register form a double buffer, so full
// vectors stream at one beat per cycle while the output drains.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_data           lanes x bit_width beat elements (lane k -> beat_idx*lanes+k)
//   i_valid, i_last  input beat valid / final beat of current vector
//   o_ready          beat can be accepted this cycle
//   o_vec, o_count   assembled vector and number of non-padded elements
//   o_valid          o_vec/o_count valid
//   i_ready          downstream accepts o_vec this cycle
module vec_gather_i8 #(
  parameter int bit_width = 16,
  parameter int length    = 32,
  parameter int lanes     = 4,
  parameter int beats     = length / lanes,
  parameter int cnt_width = $clog2(length) + 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [lanes-1:0][bit_width-1:0]    i_data,
  input  logic                               i_valid,
  input  logic                               i_last,
  output logic                               o_ready,
  output logic [length-1:0][bit_width-1:0]   o_vec,
  output logic [cnt_width-1:0]               o_count,
  output logic                               o_valid,
  input  logic                               i_ready
);

  localparam int IW = (beats > 1) ? $clog2(beats) : 1;

  typedef logic [length-1:0][bit_width-1:0] vec_t;
  typedef enum logic {FILL, FULL} state_t;

  state_t                 state_q;
  logic [IW-1:0]          beat_idx_q;
  vec_t                   fill_q;
  logic [cnt_width-1:0]   fill_cnt_q;
  vec_t                   o_vec_q;
  logic [cnt_width-1:0]   o_count_q;
  logic                   o_valid_q;

  vec_t                   merged_d;
  logic [cnt_width-1:0]   beat_cnt_d;
  logic                   accept;
  logic                   out_free;
  logic                   complete;

  assign o_ready  = (state_q == FILL) && !i_rst;
  assign accept   = i_valid && o_ready;
  assign out_free = !o_valid_q || i_ready;
  assign complete = accept && (i_last || (beat_idx_q == IW'(beats - 1)));

  // Element count if the vector ended on the current beat.
  assign beat_cnt_d = (cnt_width'(beat_idx_q) + cnt_width'(1)) * cnt_width'(lanes);

  // Fill buffer with the current beat merged in. Slots above the current beat
  // are already zero because the buffer is cleared whenever a vector leaves,
  // so the merged vector is zero-padded by construction.
  for (genvar g = 0; g < length; g++) begin : g_merge
    localparam int B = g / lanes;
    localparam int K = g % lanes;
    assign merged_d[g] = (beat_idx_q == IW'(B)) ? i_data[K] : fill_q[g];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= FILL;
      beat_idx_q <= '0;
      fill_q     <= '0;
      fill_cnt_q <= '0;
      o_vec_q    <= '0;
      o_count_q  <= '0;
      o_valid_q  <= 1'b0;
    end else begin
      // Plain drain; a load in the same cycle overrides this below.
      if (o_valid_q && i_ready) o_valid_q <= 1'b0;

      case (state_q)
        FILL: begin
          if (accept) begin
            if (complete) begin
              beat_idx_q <= '0;
              if (out_free) begin
                // Bypass the fill buffer straight into the output register.
                o_vec_q   <= merged_d;
                o_count_q <= beat_cnt_d;
                o_valid_q <= 1'b1;
                fill_q    <= '0;
              end else begin
                // Output busy: park the completed vector until it drains.
                fill_q     <= merged_d;
                fill_cnt_q <= beat_cnt_d;
                state_q    <= FULL;
              end
            end else begin
              fill_q     <= merged_d;
              beat_idx_q <= beat_idx_q + IW'(1);
            end
          end
        end
        FULL: begin
          if (out_free) begin
            o_vec_q    <= fill_q;
            o_count_q  <= fill_cnt_q;
            o_valid_q  <= 1'b1;
            fill_q     <= '0;
            beat_idx_q <= '0;
            state_q    <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign o_vec   = o_vec_q;
  assign o_count = o_count_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_vec_gather_i8.sv
module tb_vec_gather_i8;
  localparam int BW = 16;
  localparam int LEN = 32;
  localparam int LN = 4;
  localparam int BEATS = LEN / LN;
  localparam int CW = $clog2(LEN) + 1;

  typedef logic [LEN-1:0][BW-1:0] vec_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [LN-1:0][BW-1:0] i_data = '0;
  logic                  i_valid = 1'b0;
  logic                  i_last = 1'b0;
  logic                  i_ready = 1'b0;
  logic                  o_ready;
  vec_t                  o_vec;
  logic [CW-1:0]         o_count;
  logic                  o_valid;

  vec_gather_i8 #(.bit_width(BW), .length(LEN), .lanes(LN)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid),
    .i_last(i_last), .o_ready(o_ready), .o_vec(o_vec), .o_count(o_count),
    .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   n_chk = 0;
  int   n_fail = 0;
  int   drv_to = 0;
  int   acc_cyc = 0;
  bit   rnd_rdy = 1'b0;

  logic [BW-1:0] stim [LEN];
  vec_t obs_vec [$];
  int   obs_cnt [$];
  int   obs_cyc [$];

  // Record every output transfer with the cycle it was presented in.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      obs_vec.push_back(o_vec);
      obs_cnt.push_back(int'(o_count));
      obs_cyc.push_back(cyc);
    end
  end

  // Reference: the first nb beats of stim, everything above zero.
  function automatic vec_t model_vec(input int nb);
    vec_t v = '0;
    for (int i = 0; i < nb * LN; i++) v[i] = stim[i];
    return v;
  endfunction

  task automatic clear_obs();
    obs_vec.delete(); obs_cnt.delete(); obs_cyc.delete();
    drv_to = 0;
  endtask

  task automatic drive_beat(input int b, input bit last);
    bit acc;
    int w = 0;
    i_valid = 1'b1;
    i_last  = last;
    for (int k = 0; k < LN; k++) i_data[k] = stim[b*LN + k];
    do begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk); #1;
      if (rnd_rdy) i_ready = 1'($urandom);
      w++;
    end while (!acc && w < 200);
    if (!acc) drv_to++;
    acc_cyc = cyc;
  endtask

  task automatic send_vec(input int nb, input bit use_last, input bit gaps);
    for (int b = 0; b < nb; b++) begin
      drive_beat(b, use_last && (b == nb - 1));
      if (gaps) begin
        i_valid = 1'b0;
        i_last  = 1'b0;
        for (int k = 0; k < LN; k++) i_data[k] = BW'($urandom);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_in_reset: got %b expected 0", o_ready); end
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b expected 1", o_ready); end
    n_chk++; if (o_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", o_count); end
    n_chk++; if (o_vec !== '0) begin n_fail++; $display("FAIL rst_vec: got %h expected 0", o_vec); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_vector();
    vec_t exp;
    clear_obs();
    i_ready = 1'b1;
    for (int i = 0; i < LEN; i++) stim[i] = BW'(i);
    exp = model_vec(BEATS);
    send_vec(BEATS, 1'b0, 1'b0);
    idle(3);
    n_chk++; if (obs_vec.size() !== 1) begin n_fail++; $display("FAIL full_pulses: got %0d expected 1", obs_vec.size()); end
    if (obs_vec.size() > 0) begin
      n_chk++; if (obs_vec[0] !== exp) begin n_fail++; $display("FAIL full_vec: got %h expected %h", obs_vec[0], exp); end
      n_chk++; if (obs_cnt[0] !== LEN) begin n_fail++; $display("FAIL full_cnt: got %0d expected %0d", obs_cnt[0], LEN); end
      n_chk++; if (obs_cyc[0] !== acc_cyc) begin n_fail++; $display("FAIL full_latency: got cycle %0d expected %0d", obs_cyc[0], acc_cyc); end
    end
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain: got %b expected 0", o_valid); end
  endtask

  task automatic test_short_vector();
    vec_t exp;
    clear_obs();
    i_ready = 1'b1;
    for (int i = 0; i < LEN; i++) stim[i] = 16'h007F;
    exp = model_vec(3);
    send_vec(3, 1'b1, 1'b0);
    idle(3);
    n_chk++; if (obs_vec.size() !== 1) begin n_fail++; $display("FAIL short_pulses: got %0d expected 1", obs_vec.size()); end
    if (obs_vec.size() > 0) begin
      n_chk++; if (obs_vec[0] !== exp) begin n_fail++; $display("FAIL short_vec: got %h expected %h", obs_vec[0], exp); end
      n_chk++; if (obs_cnt[0] !== 12) begin n_fail++; $display("FAIL short_cnt: got %0d expected 12", obs_cnt[0]); end
    end
    // Single-beat vector: only the first lanes elements survive.
    clear_obs();
    for (int i = 0; i < LEN; i++) stim[i] = BW'($urandom);
    exp = model_vec(1);
    send_vec(1, 1'b1, 1'b0);
    idle(3);
    n_chk++; if (obs_vec.size() !== 1) begin n_fail++; $display("FAIL one_beat_pulses: got %0d expected 1", obs_vec.size()); end
    if (obs_vec.size() > 0) begin
      n_chk++; if (obs_vec[0] !== exp) begin n_fail++; $display("FAIL one_beat_vec: got %h expected %h", obs_vec[0], exp); end
      n_chk++; if (obs_cnt[0] !== LN) begin n_fail++; $display("FAIL one_beat_cnt: got %0d expected %0d", obs_cnt[0], LN); end
    end
  endtask

  task automatic test_backpressure();
    vec_t va, vb;
    clear_obs();
    i_ready = 1'b0;
    for (int i = 0; i < LEN; i++) stim[i] = 16'h0001;
    va = model_vec(BEATS);
    send_vec(BEATS, 1'b0, 1'b0);
    for (int i = 0; i < LEN; i++) stim[i] = 16'h0002;
    vb = model_vec(BEATS);
    send_vec(4, 1'b0, 1'b0);
    @(negedge clk);
    n_chk++; if (o_vec !== va) begin n_fail++; $display("FAIL bp_hold_mid: got %h expected %h", o_vec, va); end
    @(posedge clk); #1;
    for (int b = 4; b < BEATS; b++) drive_beat(b, 1'b0);
    idle(1);
    @(negedge clk);
    n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_a: got %b expected 1", o_valid); end
    n_chk++; if (o_vec !== va) begin n_fail++; $display("FAIL bp_hold_a: got %h expected %h", o_vec, va); end
    n_chk++; if (o_count !== CW'(LEN)) begin n_fail++; $display("FAIL bp_cnt_a: got %0d expected %0d", o_count, LEN); end
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", o_ready); end
    @(posedge clk); #1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (o_vec !== vb) begin n_fail++; $display("FAIL bp_vec_b: got %h expected %h", o_vec, vb); end
    n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_b: got %b expected 1", o_valid); end
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b expected 1", o_ready); end
    @(posedge clk); #1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", o_valid); end
    n_chk++; if (obs_vec.size() !== 2) begin n_fail++; $display("FAIL bp_transfers: got %0d expected 2", obs_vec.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    vec_t exp [4];
    int start;
    clear_obs();
    i_ready = 1'b1;
    start = cyc;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < LEN; i++) stim[i] = BW'($urandom);
      exp[v] = model_vec(BEATS);
      send_vec(BEATS, 1'b0, 1'b0);
    end
    idle(3);
    n_chk++; if (acc_cyc - start !== 4 * BEATS) begin n_fail++; $display("FAIL b2b_throughput: got %0d cycles expected %0d", acc_cyc - start, 4 * BEATS); end
    n_chk++; if (obs_vec.size() !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 4", obs_vec.size()); end
    for (int v = 0; v < 4 && v < obs_vec.size(); v++) begin
      n_chk++; if (obs_vec[v] !== exp[v]) begin n_fail++; $display("FAIL b2b_vec%0d: got %h expected %h", v, obs_vec[v], exp[v]); end
      if (v > 0) begin
        n_chk++; if (obs_cyc[v] - obs_cyc[v-1] !== BEATS) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", v, obs_cyc[v] - obs_cyc[v-1], BEATS); end
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t exp;
    clear_obs();
    i_ready = 1'b0;
    for (int i = 0; i < LEN; i++) stim[i] = BW'($urandom);
    send_vec(BEATS, 1'b0, 1'b0);
    for (int i = 0; i < LEN; i++) stim[i] = BW'($urandom) | 16'h8000;
    send_vec(5, 1'b0, 1'b0);
    i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0", o_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", o_valid); end
    n_chk++; if (o_count !== '0) begin n_fail++; $display("FAIL mid_rst_count: got %0d expected 0", o_count); end
    n_chk++; if (o_vec !== '0) begin n_fail++; $display("FAIL mid_rst_vec: got %h expected 0", o_vec); end
    @(posedge clk); #1;
    clear_obs();
    i_ready = 1'b1;
    for (int i = 0; i < LEN; i++) stim[i] = 16'h0003;
    exp = model_vec(BEATS);
    send_vec(BEATS, 1'b0, 1'b0);
    idle(3);
    n_chk++; if (obs_vec.size() !== 1) begin n_fail++; $display("FAIL mid_pulses: got %0d expected 1", obs_vec.size()); end
    if (obs_vec.size() > 0) begin
      n_chk++; if (obs_vec[0] !== exp) begin n_fail++; $display("FAIL mid_vec: got %h expected %h", obs_vec[0], exp); end
      n_chk++; if (obs_cnt[0] !== LEN) begin n_fail++; $display("FAIL mid_cnt: got %0d expected %0d", obs_cnt[0], LEN); end
    end
  endtask

  task automatic test_idle_gaps();
    vec_t exp;
    clear_obs();
    i_ready = 1'b1;
    for (int i = 0; i < LEN; i++) stim[i] = BW'($urandom);
    exp = model_vec(BEATS);
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(b, 1'b0);
      if (b == BEATS - 1) break;
      i_valid = 1'b0;
      for (int k = 0; k < LN; k++) i_data[k] = BW'($urandom);
      @(posedge clk); #1;
    end
    idle(3);
    n_chk++; if (obs_vec.size() !== 1) begin n_fail++; $display("FAIL gaps_pulses: got %0d expected 1", obs_vec.size()); end
    if (obs_vec.size() > 0) begin
      n_chk++; if (obs_vec[0] !== exp) begin n_fail++; $display("FAIL gaps_vec: got %h expected %h", obs_vec[0], exp); end
      n_chk++; if (obs_cnt[0] !== LEN) begin n_fail++; $display("FAIL gaps_cnt: got %0d expected %0d", obs_cnt[0], LEN); end
      n_chk++; if (obs_cyc[0] !== acc_cyc) begin n_fail++; $display("FAIL gaps_latency: got cycle %0d expected %0d", obs_cyc[0], acc_cyc); end
    end
  endtask

  task automatic test_random_stream();
    vec_t exp_vec [$];
    int   exp_cnt [$];
    int   nb, w;
    bit   lst, gap;
    clear_obs();
    rnd_rdy = 1'b1;
    for (int v = 0; v < 16; v++) begin
      nb  = $urandom_range(1, BEATS);
      lst = (nb < BEATS) ? 1'b1 : 1'($urandom);
      gap = 1'($urandom);
      for (int i = 0; i < LEN; i++) stim[i] = BW'($urandom);
      exp_vec.push_back(model_vec(nb));
      exp_cnt.push_back(nb * LN);
      send_vec(nb, lst, gap);
    end
    rnd_rdy = 1'b0;
    i_ready = 1'b1;
    i_valid = 1'b0;
    w = 0;
    while (obs_vec.size() < exp_vec.size() && w < 200) begin @(posedge clk); #1; w++; end
    idle(2);
    n_chk++; if (obs_vec.size() !== exp_vec.size()) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", obs_vec.size(), exp_vec.size()); end
    for (int v = 0; v < exp_vec.size() && v < obs_vec.size(); v++) begin
      n_chk++; if (obs_vec[v] !== exp_vec[v]) begin n_fail++; $display("FAIL rnd_vec%0d: got %h expected %h", v, obs_vec[v], exp_vec[v]); end
      n_chk++; if (obs_cnt[v] !== exp_cnt[v]) begin n_fail++; $display("FAIL rnd_cnt%0d: got %0d expected %0d", v, obs_cnt[v], exp_cnt[v]); end
    end
    n_chk++; if (drv_to !== 0) begin n_fail++; $display("FAIL rnd_accept_timeout: got %0d expected 0", drv_to); end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_short_vector();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_idle_gaps();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_gather_i8.md
Name: vec_gather_i8

Overview:
- Stream-to-vector gatherer that produces the parallel vectors consumed by the adder-tree vector sum.
- Accepts `lanes` elements per beat on a valid/ready stream and assembles `length`-element vectors.
- Zero-pads short vectors terminated by `i_last`.
- Presents each completed vector on a valid/ready output. Double buffered (fill buffer plus output register), so full-length vectors sustain one beat per cycle.

Parameters:
- bit_width, 16, element width in bits.
- length, 32, elements per output vector; power of two, >= lanes.
- lanes, 4, elements accepted per input beat; power of two, divides length.
- beats, length/lanes, derived: beats per full vector.
- cnt_width, $clog2(length)+1, derived: width of o_count.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_data  input  [bit_width-1:0] x lanes  beat elements; lane k goes to vector index beat_idx*lanes+k.
- i_valid  input  1  input beat valid.
- i_last  input  1  beat is the final beat of the current vector (qualified by i_valid).
- o_ready  output  1  gatherer can accept a beat this cycle.
- o_vec  output  [bit_width-1:0] x length  assembled vector.
- o_count  output  cnt_width  number of valid (non-padded) elements in o_vec; multiple of lanes, 1..length.
- o_valid  output  1  o_vec/o_count valid.
- i_ready  input  1  downstream accepts o_vec this cycle.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - o_valid=0, o_vec all zero, o_count=0.
  - Fill buffer zeroed, beat_idx=0, state=FILL.
  - Any partial vector is discarded.
  - o_ready is 0 while i_rst=1 and 1 in the first cycle after.
- Handshakes:
  - Input beat accepted iff i_valid && o_ready.
  - Output transfer iff o_valid && i_ready.
  - out_free = !o_valid || i_ready (combinational).
- Output stability: o_vec and o_count are held stable while o_valid && !i_ready.
- States:
  - FILL: o_ready=1. Each accepted beat writes its lanes into the fill buffer at beat_idx and increments beat_idx.
  - Completing beat: an accepted beat with i_last=1 or beat_idx==beats-1.
    - Completing beat and out_free: at the same edge, o_vec <= fill buffer with this beat merged and all higher indices zero; o_count <= (beat_idx+1)*lanes; o_valid <= 1. The fill buffer clears, beat_idx resets to 0, and the state stays FILL.
    - Completing beat and !out_free: the beat is written into the fill buffer, the stored count is captured, and the state goes to FULL.
  - FULL: o_ready=0; the fill buffer is held. When out_free, the buffer (zero-padded) and its count load into the output register, o_valid <= 1, the buffer clears, beat_idx=0, and the state goes to FILL.
- Plain output drain: o_valid <= 0 when a transfer occurs without a new load that cycle.
- Simultaneous transfer and load: o_valid stays 1 and the new vector replaces the old one at the same edge (no bubble).
- Latency: completing beat accepted at edge N gives o_valid=1 from cycle N+1 when the output is free.
- Throughput: full vectors sustain 1 beat/cycle with i_ready held high.
- i_last on the last natural beat (beat_idx==beats-1) is a normal full vector; no extra empty vector is produced.
- i_last on beat 0 gives o_count=lanes, with indices >= lanes zero.
- i_data is ignored when the beat is not accepted.
- No arithmetic on data; elements pass bit-exact.

Test Plan:
- Full vector, length=32, lanes=4, i_ready=1: 8 consecutive beats with element values 0..31 → o_vec[i]=i, o_count=32, o_valid high exactly 1 cycle, asserted the cycle after beat 7.
- Short vector: 3 beats of value 8'h7F with i_last on beat 2 → o_vec[0..11]=16'h007F, o_vec[12..31]=0, o_count=12.
- Backpressure: i_ready=0 while two full vectors A (all 1s) then B (all 2s) are sent.
  - A presented and held stable.
  - After B's 8th beat, o_ready=0 (FULL).
  - Raise i_ready for 1 cycle: B appears next cycle and o_ready returns to 1.
  - Raise i_ready again: B transfers and o_valid falls.
- Back-to-back streaming: 4 full vectors with no gaps and i_ready=1 → 32 input beats in 32 cycles, 4 o_valid pulses spaced exactly 8 cycles apart, correct contents each.
- Reset mid-operation: 5 beats of a vector, then assert i_rst for 1 cycle, then send 8 beats of value 3.
  - During reset: o_valid=0, o_count=0, o_vec zero.
  - Next vector is all 3s with o_count=32, with no residue from the aborted beats.
- Idle gaps: i_valid toggling 1/0 every cycle for one vector → identical result to the gap-free case; o_valid rises 1 cycle after the final beat.
